// File: rtl/icache_pf_pkg.sv
// icache_pf_pkg: state encoding and PLRU tree helpers shared by the prefetching I-cache controller
package icache_pf_pkg;
  typedef enum logic [1:0] {HIT_CHECK = 2'd0, FILL = 2'd1, PF_FILL = 2'd2} state_e;
  // Trees up to 16 ways are handled in fixed 15-bit/16-bit containers; ways selects the live part.
  function automatic logic [3:0] plru_victim(input logic [14:0] tree, input logic [15:0] valid, input int ways);
    logic [31:0] t;
    logic [4:0] node;
    logic [3:0] v;
    t = 32'(tree);
    node = 5'd1;
    for (int i = 0; i < 4; i++) if (32'(node) < ways) node = {node[3:0], t[node - 5'd1]};
    v = 4'(node - 5'(ways));
    for (int i = 15; i >= 0; i--) if (i < ways && !valid[i]) v = 4'(i);
    return v;
  endfunction
  function automatic logic [14:0] plru_touch(input logic [14:0] tree, input logic [3:0] way, input int ways);
    logic [31:0] t;
    logic [4:0] n;
    t = 32'(tree);
    n = 5'(way) + 5'(ways);
    for (int i = 0; i < 4; i++)
      if (n > 5'd1) begin
        t[5'(n[4:1]) - 5'd1] = ~n[0];
        n = 5'(n[4:1]);
      end
    return t[14:0];
  endfunction
endpackage

// File: rtl/icache_pf_ctrl_plru.sv
// plru_tree: victim choice on one tree and touch update on another, sized for WAYS
module plru_tree import icache_pf_pkg::*; #(
  parameter int WAYS = 4,
  localparam int WB = $clog2(WAYS),
  localparam int PW = WAYS - 1
) (
  input  logic [PW-1:0]   vtree,
  input  logic [WAYS-1:0] valid,
  input  logic [PW-1:0]   ttree,
  input  logic [WB-1:0]   way,
  output logic [WB-1:0]   victim,
  output logic [PW-1:0]   touched
);
  logic [14:0] vt, tt;
  logic [15:0] v16;
  always_comb begin
    vt = '0;
    vt[PW-1:0] = vtree;
    tt = '0;
    tt[PW-1:0] = ttree;
    v16 = '1;
    v16[WAYS-1:0] = valid;
    victim = WB'(plru_victim(vt, v16, WAYS));
    touched = PW'(plru_touch(tt, 4'(way), WAYS));
  end
endmodule

// File: rtl/icache_pf_ctrl.sv
// icache_pf_ctrl: read-only WAYS-way I-cache controller with next-line prefetch
module icache_pf_ctrl import icache_pf_pkg::*; #(
  parameter int WAYS = 4,
  parameter int CNT_W = 16,
  localparam int WB = $clog2(WAYS),
  localparam int PW = WAYS - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_read,
  output logic             mem_resp,
  input  logic             pf_enable,
  input  logic [WAYS-1:0]  hit_i,
  input  logic [WAYS-1:0]  valid_i,
  input  logic [PW-1:0]    plru_i,
  input  logic [WAYS-1:0]  nhit_i,
  input  logic [WAYS-1:0]  nvalid_i,
  input  logic [PW-1:0]    nplru_i,
  input  logic             pf_set_match_i,
  output logic             pf_addr_load,
  output logic [WB-1:0]    way_sel,
  output logic [WAYS-1:0]  way_load,
  output logic             fill_sel,
  output logic             pmem_addr_sel,
  output logic             plru_load,
  output logic [PW-1:0]    plru_o,
  output logic             pmem_read,
  input  logic             pmem_resp,
  output logic [CNT_W-1:0] pf_issue_cnt
);
  state_e state, state_n;
  logic [WB-1:0] hit_way, dm_victim, pf_victim, dm_vic_n, pf_vic_n;
  logic [PW-1:0] hit_touch, fill_touch;
  logic hit, miss, serve, launch, dm_done, pf_done, pf_block;
  always_comb begin
    hit_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) if (hit_i[i]) hit_way = WB'(i);
  end
  // The second tree unit also hosts the fill-time touch so both units stay fully used.
  plru_tree #(.WAYS(WAYS)) u_dm (
    .vtree(plru_i), .valid(valid_i), .ttree(plru_i), .way(hit_way),
    .victim(dm_vic_n), .touched(hit_touch)
  );
  plru_tree #(.WAYS(WAYS)) u_nl (
    .vtree(nplru_i), .valid(nvalid_i), .ttree(plru_i), .way(dm_victim),
    .victim(pf_vic_n), .touched(fill_touch)
  );
  always_comb begin
    hit = |hit_i;
    pf_block = pf_set_match_i && hit_way == pf_victim;
    miss = !rst && state == HIT_CHECK && mem_read && !hit;
    dm_done = !rst && state == FILL && pmem_resp;
    pf_done = !rst && state == PF_FILL && pmem_resp;
    serve = !rst && mem_read && hit && (state == HIT_CHECK || (state == PF_FILL && !pmem_resp && !pf_block));
    launch = serve && state == HIT_CHECK && pf_enable && nhit_i == '0;
    mem_resp = serve;
    way_sel = serve ? hit_way : '0;
    plru_load = serve || dm_done;
    plru_o = serve ? hit_touch : dm_done ? fill_touch : '0;
    pf_addr_load = launch;
    way_load = dm_done ? WAYS'(1) << dm_victim : pf_done ? WAYS'(1) << pf_victim : '0;
    fill_sel = pf_done;
    pmem_addr_sel = !rst && state == PF_FILL;
    pmem_read = !rst && state != HIT_CHECK;
    state_n = launch ? PF_FILL : miss ? FILL : (dm_done || pf_done) ? HIT_CHECK : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= HIT_CHECK;
      dm_victim <= '0;
      pf_victim <= '0;
      pf_issue_cnt <= '0;
    end else begin
      state <= state_n;
      if (miss) dm_victim <= dm_vic_n;
      if (launch) pf_victim <= pf_vic_n;
      if (launch && pf_issue_cnt != '1) pf_issue_cnt <= pf_issue_cnt + 1'b1;
    end
endmodule

// File: tb/tb_icache_pf_ctrl.sv
// tb_icache_pf_ctrl: directed scoreboard bench for a 4-way and an 8-way controller
module tb_icache_pf_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic a_rst, a_mem_read, a_mem_resp, a_pf_enable, a_pf_set_match, a_pf_addr_load;
  logic a_fill_sel, a_pmem_addr_sel, a_plru_load, a_pmem_read, a_pmem_resp;
  logic [3:0] a_hit, a_valid, a_nhit, a_nvalid, a_way_load;
  logic [2:0] a_plru, a_nplru, a_plru_o;
  logic [1:0] a_way_sel;
  logic [15:0] a_cnt;

  logic b_rst, b_mem_read, b_mem_resp, b_pf_enable, b_pf_set_match, b_pf_addr_load;
  logic b_fill_sel, b_pmem_addr_sel, b_plru_load, b_pmem_read, b_pmem_resp;
  logic [7:0] b_hit, b_valid, b_nhit, b_nvalid, b_way_load;
  logic [6:0] b_plru, b_nplru, b_plru_o;
  logic [2:0] b_way_sel;
  logic [1:0] b_cnt;

  icache_pf_ctrl #(.WAYS(4), .CNT_W(16)) dut_a (
    .clk(clk), .rst(a_rst), .mem_read(a_mem_read), .mem_resp(a_mem_resp), .pf_enable(a_pf_enable),
    .hit_i(a_hit), .valid_i(a_valid), .plru_i(a_plru), .nhit_i(a_nhit), .nvalid_i(a_nvalid),
    .nplru_i(a_nplru), .pf_set_match_i(a_pf_set_match), .pf_addr_load(a_pf_addr_load),
    .way_sel(a_way_sel), .way_load(a_way_load), .fill_sel(a_fill_sel), .pmem_addr_sel(a_pmem_addr_sel),
    .plru_load(a_plru_load), .plru_o(a_plru_o), .pmem_read(a_pmem_read), .pmem_resp(a_pmem_resp),
    .pf_issue_cnt(a_cnt)
  );

  icache_pf_ctrl #(.WAYS(8), .CNT_W(2)) dut_b (
    .clk(clk), .rst(b_rst), .mem_read(b_mem_read), .mem_resp(b_mem_resp), .pf_enable(b_pf_enable),
    .hit_i(b_hit), .valid_i(b_valid), .plru_i(b_plru), .nhit_i(b_nhit), .nvalid_i(b_nvalid),
    .nplru_i(b_nplru), .pf_set_match_i(b_pf_set_match), .pf_addr_load(b_pf_addr_load),
    .way_sel(b_way_sel), .way_load(b_way_load), .fill_sel(b_fill_sel), .pmem_addr_sel(b_pmem_addr_sel),
    .plru_load(b_plru_load), .plru_o(b_plru_o), .pmem_read(b_pmem_read), .pmem_resp(b_pmem_resp),
    .pf_issue_cnt(b_cnt)
  );

  string tag_q[$];
  logic [31:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  task automatic push(input string t, input logic [31:0] e);
    tag_q.push_back(t);
    exp_q.push_back(e);
  endtask

  task automatic pop(input logic [31:0] obs);
    string t;
    logic [31:0] e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $error("FAIL sb_underflow: observed 'h%0h with no expectation queued", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        fails++;
        $error("FAIL %s: observed 'h%0h expected 'h%0h", t, obs, e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    {a_mem_read, a_pf_enable, a_pf_set_match, a_pmem_resp} = '0;
    {a_hit, a_valid, a_nhit, a_nvalid, a_plru, a_nplru} = '0;
    {b_mem_read, b_pf_enable, b_pf_set_match, b_pmem_resp} = '0;
    {b_hit, b_valid, b_nhit, b_nvalid, b_plru, b_nplru} = '0;
    a_rst = 1'b1;
    b_rst = 1'b1;
    a_mem_read = 1'b1;
    a_hit = 4'b0001;
    repeat (2) tick();
    push("rst_mem_resp", 0); push("rst_pmem_read", 0); push("rst_plru_load", 0); push("rst_cnt", 0);
    pop(a_mem_resp); pop(a_pmem_read); pop(a_plru_load); pop(a_cnt);
    a_rst = 1'b0;
    b_rst = 1'b0;
    a_mem_read = 1'b0;
    a_hit = '0;
    tick();
    a_valid = 4'b0111; a_plru = 3'b101; a_mem_read = 1'b1;
    #2;
    push("miss_hc_pmem_read", 0); push("miss_hc_mem_resp", 0);
    pop(a_pmem_read); pop(a_mem_resp);
    tick();
    #2;
    push("fill_pmem_read", 1); push("fill_addr_sel", 0); push("fill_way_load", 0);
    pop(a_pmem_read); pop(a_pmem_addr_sel); pop(a_way_load);
    tick();
    a_mem_read = 1'b0;
    #2;
    push("fill_hold_pmem_read", 1);
    pop(a_pmem_read);
    tick();
    a_pmem_resp = 1'b1;
    #2;
    push("fill_way_load", 4'b1000); push("fill_plru_o", 3'b000); push("fill_plru_load", 1);
    push("fill_sel", 0); push("fill_mem_resp", 0);
    pop(a_way_load); pop(a_plru_o); pop(a_plru_load); pop(a_fill_sel); pop(a_mem_resp);
    tick();
    a_pmem_resp = 1'b0; a_mem_read = 1'b1; a_hit = 4'b1000; a_valid = 4'b1111; a_plru = 3'b111;
    #2;
    push("refill_mem_resp", 1); push("refill_way_sel", 3); push("refill_plru_o", 3'b010);
    push("refill_pmem_read", 0); push("refill_pf_addr_load", 0);
    pop(a_mem_resp); pop(a_way_sel); pop(a_plru_o); pop(a_pmem_read); pop(a_pf_addr_load);
    tick();
    a_hit = 4'b0010; a_plru = 3'b000; a_pf_enable = 1'b1; a_nhit = '0; a_nvalid = 4'b1011; a_nplru = '0;
    #2;
    push("launch_mem_resp", 1); push("launch_plru_o", 3'b001); push("launch_way_sel", 1);
    push("launch_pf_addr_load", 1); push("launch_cnt", 0);
    pop(a_mem_resp); pop(a_plru_o); pop(a_way_sel); pop(a_pf_addr_load); pop(a_cnt);
    tick();
    a_hit = 4'b0100; a_pf_set_match = 1'b1;
    #2;
    push("pf_pmem_read", 1); push("pf_addr_sel", 1); push("pf_cnt", 1); push("pf_stall_mem_resp", 0);
    pop(a_pmem_read); pop(a_pmem_addr_sel); pop(a_cnt); pop(a_mem_resp);
    tick();
    #2;
    push("pf_stall2_mem_resp", 0); push("pf_stall2_pmem_read", 1);
    pop(a_mem_resp); pop(a_pmem_read);
    tick();
    a_pmem_resp = 1'b1;
    #2;
    push("pf_done_way_load", 4'b0100); push("pf_done_fill_sel", 1); push("pf_done_plru_load", 0);
    push("pf_done_mem_resp", 0);
    pop(a_way_load); pop(a_fill_sel); pop(a_plru_load); pop(a_mem_resp);
    tick();
    a_pmem_resp = 1'b0; a_pf_enable = 1'b0;
    #2;
    push("served_mem_resp", 1); push("served_way_sel", 2); push("served_plru_o", 3'b100);
    push("served_pmem_read", 0);
    pop(a_mem_resp); pop(a_way_sel); pop(a_plru_o); pop(a_pmem_read);
    tick();
    a_pf_enable = 1'b1; a_hit = 4'b0001; a_nvalid = 4'b1111; a_nplru = 3'b000; a_pf_set_match = 1'b0;
    #2;
    push("l2_pf_addr_load", 1); push("l2_mem_resp", 1);
    pop(a_pf_addr_load); pop(a_mem_resp);
    tick();
    #2;
    push("pfhit_mem_resp", 1); push("pfhit_pmem_read", 1); push("pfhit_way_sel", 0);
    push("pfhit_plru_load", 1); push("pfhit_plru_o", 3'b011); push("pfhit_pf_addr_load", 0);
    push("pfhit_cnt", 2);
    pop(a_mem_resp); pop(a_pmem_read); pop(a_way_sel); pop(a_plru_load); pop(a_plru_o);
    pop(a_pf_addr_load); pop(a_cnt);
    a_pf_set_match = 1'b1;
    #1;
    push("pfblk_mem_resp", 0);
    pop(a_mem_resp);
    tick();
    a_pf_set_match = 1'b0; a_hit = '0; a_pf_enable = 1'b0;
    #2;
    push("pfmiss_mem_resp", 0); push("pfmiss_pmem_read", 1); push("pfmiss_addr_sel", 1);
    pop(a_mem_resp); pop(a_pmem_read); pop(a_pmem_addr_sel);
    tick();
    a_pmem_resp = 1'b1; a_hit = 4'b0001;
    #2;
    push("pf2_way_load", 4'b0001); push("pf2_mem_resp", 0);
    pop(a_way_load); pop(a_mem_resp);
    tick();
    a_pmem_resp = 1'b0; a_mem_read = 1'b0;
    #2;
    push("idle_pmem_read", 0); push("idle_cnt", 2);
    pop(a_pmem_read); pop(a_cnt);
    tick();
    a_mem_read = 1'b1; a_hit = '0;
    tick();
    #2;
    push("rstfill_pmem_read", 1);
    pop(a_pmem_read);
    a_rst = 1'b1;
    #1;
    push("rstfill_drop", 0); push("rstfill_cnt", 0);
    pop(a_pmem_read); pop(a_cnt);
    tick();
    a_rst = 1'b0; a_mem_read = 1'b0;
    tick();
    a_mem_read = 1'b1; a_hit = 4'b0001;
    #2;
    push("post_rst_pmem_read", 0); push("post_rst_mem_resp", 1);
    pop(a_pmem_read); pop(a_mem_resp);
    a_mem_read = 1'b0;

    tick();
    b_valid = 8'hFF; b_plru = 7'h7F; b_mem_read = 1'b1;
    tick();
    b_pmem_resp = 1'b1;
    #2;
    push("w8_way_load", 8'h80); push("w8_plru_o", 7'h3A);
    pop(b_way_load); pop(b_plru_o);
    tick();
    b_pmem_resp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b_hit = 8'h01; b_pf_enable = 1'b1; b_nhit = '0; b_nvalid = 8'hFF; b_nplru = '0; b_mem_read = 1'b1;
      #2;
      push("w8_launch", 1);
      pop(b_pf_addr_load);
      tick();
      b_pmem_resp = 1'b1; b_mem_read = 1'b0;
      #2;
      push("w8_pf_way_load", 8'h01);
      pop(b_way_load);
      tick();
      b_pmem_resp = 1'b0;
      #2;
      push("w8_cnt", (i < 3) ? i + 1 : 3);
      pop(b_cnt);
    end

    tests++;
    assert (exp_q.size() == 0) else begin
      fails++;
      $error("FAIL sb_leftover: %0d expectations unconsumed, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
